cache_ctrl: RTL and testbench

Sequencing controller for the L1 cache model: accepts one trace command (READ, WRITE, I_FETCH, L2_INVAL, L2_DATA_RQ, CLR, PRINT) at a time over a valid/ready handshake and performs the tag lookup in a direct-mapped tag/valid/dirty array. It issues line fills and writebacks to L2 over a request handshake and maintains the read/write/hit/miss statistics counters. It sits between the trace reader and the L2 interface model.

---
 rtl/cache_ctrl_pkg.sv | 31 +++
 rtl/cache_tag_array.sv | 60 ++++++
 rtl/cache_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the L1 cache sequencing controller: trace commands,
// L2 request opcodes and the controller state encoding.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_READ       = 3'd0,
    CMD_WRITE      = 3'd1,
    CMD_I_FETCH    = 3'd2,
    CMD_L2_INVAL   = 3'd3,
    CMD_L2_DATA_RQ = 3'd4,
    CMD_CLR        = 3'd5,
    CMD_PRINT      = 3'd6,
    CMD_INVALID    = 3'd7
  } cmd_t;

  typedef enum logic {
    L2_RD_LINE = 1'b0,
    L2_WB_LINE = 1'b1
  } l2_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB_REQ,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_CLEAR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cache_tag_array.sv
// Direct-mapped tag/valid/dirty storage: combinational read, one write port
// with independent field enables. Only valid/dirty need a reset value.
module cache_tag_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               we_tag,
  input  logic               we_valid,
  input  logic               we_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic               wr_dirty
);
  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_q   [SETS];
  logic [TAG_W-1:0] tag_d   [SETS];
  logic             valid_q [SETS];
  logic             valid_d [SETS];
  logic             dirty_q [SETS];
  logic             dirty_d [SETS];

  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
      logic sel;
      assign sel         = (wr_idx == INDEX_W'(gi));
      assign tag_d[gi]   = (sel && we_tag)   ? wr_tag   : tag_q[gi];
      assign valid_d[gi] = (sel && we_valid) ? wr_valid : valid_q[gi];
      assign dirty_d[gi] = (sel && we_dirty) ? wr_dirty : dirty_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// L1 cache sequencing controller: one trace command at a time, tag lookup,
// L2 fill/writeback requests and saturating hit/miss statistics.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 6,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_err,
  output logic              print_pulse,
  output logic              busy,
  output logic              l2_req_valid,
  input  logic              l2_req_ready,
  output logic              l2_req_op,
  output logic [ADDR_W-1:0] l2_req_addr,
  input  logic              l2_rsp_valid,
  output logic [CNT_W-1:0]  cache_read,
  output logic [CNT_W-1:0]  cache_write,
  output logic [CNT_W-1:0]  cache_hit,
  output logic [CNT_W-1:0]  cache_miss
);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [INDEX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                req_ready_q, req_ready_d, busy_q, busy_d;
  logic                resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
  logic                resp_err_q, resp_err_d, print_pulse_q, print_pulse_d;
  logic                l2_req_valid_q, l2_req_valid_d;
  l2_op_t              l2_req_op_q, l2_req_op_d;
  logic [ADDR_W-1:0]   l2_req_addr_q, l2_req_addr_d;

  logic [INDEX_W-1:0]  idx, wr_idx;
  logic [TAG_W-1:0]    req_tag, arr_tag;
  logic                arr_valid, arr_dirty, hit;
  logic                we_tag, we_valid, we_dirty, wr_valid, wr_dirty;
  logic                unused_offset;

  assign idx           = line_q[INDEX_W-1:0];
  assign req_tag       = line_q[LINE_W-1:INDEX_W];
  assign hit           = arr_valid && (arr_tag == req_tag);
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  cache_tag_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tags (
    .clk(clk), .rst_n(rst_n),
    .rd_idx(idx), .rd_tag(arr_tag), .rd_valid(arr_valid), .rd_dirty(arr_dirty),
    .wr_idx(wr_idx), .we_tag(we_tag), .we_valid(we_valid), .we_dirty(we_dirty),
    .wr_tag(req_tag), .wr_valid(wr_valid), .wr_dirty(wr_dirty)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    line_d     = line_q;
    clr_idx_d  = clr_idx_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wr_idx     = idx;
    we_tag     = 1'b0;
    we_valid   = 1'b0;
    we_dirty   = 1'b0;
    wr_valid   = 1'b0;
    wr_dirty   = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        cmd_d  = cmd_t'(req_cmd);
        line_d = req_addr[ADDR_W-1:OFFSET_W];
        case (cmd_t'(req_cmd))
          CMD_CLR: begin
            state_d    = ST_CLEAR;
            clr_idx_d  = '0;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
          end
          CMD_PRINT, CMD_INVALID: state_d = ST_DONE;
          default:                state_d = ST_LOOKUP;
        endcase
      end
      ST_LOOKUP: begin
        state_d = ST_DONE;
        case (cmd_q)
          CMD_READ, CMD_I_FETCH, CMD_WRITE: begin
            if (cmd_q == CMD_WRITE) wr_cnt_d = sat_inc(wr_cnt_q);
            else                    rd_cnt_d = sat_inc(rd_cnt_q);
            if (hit) begin
              hit_cnt_d = sat_inc(hit_cnt_q);
              we_dirty  = (cmd_q == CMD_WRITE);
              wr_dirty  = 1'b1;
            end else begin
              miss_cnt_d = sat_inc(miss_cnt_q);
              state_d    = (arr_valid && arr_dirty) ? ST_WB_REQ : ST_FILL_REQ;
            end
          end
          CMD_L2_INVAL: begin
            we_valid = hit;
            we_dirty = hit;
          end
          CMD_L2_DATA_RQ: if (hit && arr_dirty) state_d = ST_WB_REQ;
          default: ;
        endcase
      end
      ST_WB_REQ: if (l2_req_ready) begin
        // A snoop writeback leaves the line resident but clean.
        if (cmd_q == CMD_L2_DATA_RQ) begin
          we_dirty = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: if (l2_req_ready) state_d = ST_FILL_WAIT;
      ST_FILL_WAIT: if (l2_rsp_valid) begin
        we_tag   = 1'b1;
        we_valid = 1'b1;
        we_dirty = 1'b1;
        wr_valid = 1'b1;
        wr_dirty = (cmd_q == CMD_WRITE);
        state_d  = ST_DONE;
      end
      ST_CLEAR: begin
        wr_idx    = clr_idx_q;
        we_valid  = 1'b1;
        we_dirty  = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == {INDEX_W{1'b1}}) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d    = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
    resp_valid_d   = (state_d == ST_DONE);
    resp_hit_d     = (state_d == ST_DONE) &&
                     (((state_q == ST_LOOKUP) && hit) || (state_q == ST_WB_REQ));
    resp_err_d     = (state_q == ST_IDLE) && (state_d == ST_DONE) && (cmd_d == CMD_INVALID);
    print_pulse_d  = (state_q == ST_IDLE) && (state_d == ST_DONE) && (cmd_d == CMD_PRINT);
    l2_req_valid_d = (state_d == ST_WB_REQ) || (state_d == ST_FILL_REQ);
    l2_req_op_d    = (state_d == ST_WB_REQ) ? L2_WB_LINE : L2_RD_LINE;
    // The array is not written while a request is pending, so the address stays put.
    l2_req_addr_d  = {(state_d == ST_WB_REQ) ? arr_tag : req_tag, idx, {OFFSET_W{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cmd_q          <= CMD_READ;
      line_q         <= '0;
      clr_idx_q      <= '0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_err_q     <= 1'b0;
      print_pulse_q  <= 1'b0;
      l2_req_valid_q <= 1'b0;
      l2_req_op_q    <= L2_RD_LINE;
      l2_req_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      line_q         <= line_d;
      clr_idx_q      <= clr_idx_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
      resp_valid_q   <= resp_valid_d;
      resp_hit_q     <= resp_hit_d;
      resp_err_q     <= resp_err_d;
      print_pulse_q  <= print_pulse_d;
      l2_req_valid_q <= l2_req_valid_d;
      l2_req_op_q    <= l2_req_op_d;
      l2_req_addr_q  <= l2_req_addr_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign resp_err     = resp_err_q;
  assign print_pulse  = print_pulse_q;
  assign l2_req_valid = l2_req_valid_q;
  assign l2_req_op    = l2_req_op_q;
  assign l2_req_addr  = l2_req_addr_q;
  assign cache_read   = rd_cnt_q;
  assign cache_write  = wr_cnt_q;
  assign cache_hit    = hit_cnt_q;
  assign cache_miss   = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a command table with hand-computed results,
// plus reset-abort sequences during an outstanding L2 request.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_cmd;
  logic [31:0] req_addr;
  logic        resp_valid, resp_hit, resp_err, print_pulse, busy;
  logic        l2_req_valid, l2_req_ready, l2_req_op, l2_rsp_valid;
  logic [31:0] l2_req_addr;
  logic [31:0] cache_read, cache_write, cache_hit, cache_miss;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err),
    .print_pulse(print_pulse), .busy(busy),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_op(l2_req_op),
    .l2_req_addr(l2_req_addr), .l2_rsp_valid(l2_rsp_valid),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_hit(cache_hit), .cache_miss(cache_miss)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    int          rdy_wait;
    logic        exp_hit;
    logic        exp_err;
    int          exp_prn;
    int          exp_lat;
    int          exp_wb;
    logic [31:0] exp_wb_addr;
    int          exp_rd;
    logic [31:0] exp_rd_addr;
    logic [31:0] r, w, h, m;
  } vec_t;

  typedef struct {
    int          n_wb, n_rd, prn, lat, busy_cnt;
    logic [31:0] wb_a, rd_a, r, w, h, m;
    logic        hit, err, stable, rdy_ok, done;
  } res_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command and plays the L2 side until resp_valid or timeout.
  task automatic run_cmd(input logic [2:0] cmd, input logic [31:0] addr,
                         input int rdy_wait, output res_t r);
    logic        pend, first_op;
    logic [31:0] first_addr;
    int          pend_cnt, rsp_cnt;
    r = '{default: 0};
    r.stable = 1'b1;
    r.rdy_ok = 1'b1;
    pend = 1'b0; first_op = 1'b0; first_addr = '0; pend_cnt = 0; rsp_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      l2_rsp_valid = 1'b0;
      if (busy) r.busy_cnt++;
      if (busy && req_ready) r.rdy_ok = 1'b0;
      if (print_pulse) r.prn++;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) l2_rsp_valid = 1'b1;
      end
      if (l2_req_valid) begin
        if (!pend) begin
          pend = 1'b1; pend_cnt = 0; first_op = l2_req_op; first_addr = l2_req_addr;
        end else if (l2_req_op !== first_op || l2_req_addr !== first_addr) begin
          r.stable = 1'b0;
        end
        if (pend_cnt < rdy_wait) begin
          l2_req_ready = 1'b0;
          // Stray fill response while a writeback is pending must be ignored.
          if (pend_cnt == 0 && first_op) l2_rsp_valid = 1'b1;
          pend_cnt++;
        end else begin
          l2_req_ready = 1'b1;
          pend = 1'b0;
          if (first_op) begin r.n_wb++; r.wb_a = first_addr; end
          else begin r.n_rd++; r.rd_a = first_addr; rsp_cnt = 3; end
        end
      end else begin
        l2_req_ready = 1'b0;
      end
      if (resp_valid) begin
        r.done = 1'b1; r.lat = cyc; r.hit = resp_hit; r.err = resp_err;
        r.r = cache_read; r.w = cache_write; r.h = cache_hit; r.m = cache_miss;
        break;
      end
      @(negedge clk);
    end
    l2_req_ready = 1'b0;
    l2_rsp_valid = 1'b0;
  endtask

  vec_t vt[19];
  res_t rs;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 3'd0; req_addr = '0;
    l2_req_ready = 1'b0; l2_rsp_valid = 1'b0;

    //        cmd            addr        wt hit   err   prn lat wb addr         rd addr          r      w      h      m
    vt[0]  = '{CMD_READ,       32'h00001040, 0, 1'b0, 1'b0, 0, -1, 0, 32'h0,        1, 32'h00001040, 32'd1, 32'd0, 32'd0, 32'd1};
    vt[1]  = '{CMD_READ,       32'h00001044, 0, 1'b1, 1'b0, 0,  2, 0, 32'h0,        0, 32'h0,        32'd2, 32'd0, 32'd1, 32'd1};
    vt[2]  = '{CMD_WRITE,      32'h00001050, 0, 1'b1, 1'b0, 0,  2, 0, 32'h0,        0, 32'h0,        32'd2, 32'd1, 32'd2, 32'd1};
    vt[3]  = '{CMD_READ,       32'h00011040, 4, 1'b0, 1'b0, 0, -1, 1, 32'h00001040, 1, 32'h00011040, 32'd3, 32'd1, 32'd2, 32'd2};
    vt[4]  = '{CMD_WRITE,      32'h00011048, 0, 1'b1, 1'b0, 0,  2, 0, 32'h0,        0, 32'h0,        32'd3, 32'd2, 32'd3, 32'd2};
    vt[5]  = '{CMD_L2_DATA_RQ, 32'h00011040, 0, 1'b1, 1'b0, 0,  3, 1, 32'h00011040, 0, 32'h0,        32'd3, 32'd2, 32'd3, 32'd2};
    vt[6]  = '{CMD_L2_DATA_RQ, 32'h00011040, 0, 1'b1, 1'b0, 0,  2, 0, 32'h0,        0, 32'h0,        32'd3, 32'd2, 32'd3, 32'd2};
    vt[7]  = '{CMD_READ,       32'h00011040, 0, 1'b1, 1'b0, 0,  2, 0, 32'h0,        0, 32'h0,        32'd4, 32'd2, 32'd4, 32'd2};
    vt[8]  = '{CMD_L2_INVAL,   32'h00011040, 0, 1'b1, 1'b0, 0,  2, 0, 32'h0,        0, 32'h0,        32'd4, 32'd2, 32'd4, 32'd2};
    vt[9]  = '{CMD_READ,       32'h00011040, 0, 1'b0, 1'b0, 0, -1, 0, 32'h0,        1, 32'h00011040, 32'd5, 32'd2, 32'd4, 32'd3};
    vt[10] = '{CMD_WRITE,      32'h00002080, 0, 1'b0, 1'b0, 0, -1, 0, 32'h0,        1, 32'h00002080, 32'd5, 32'd3, 32'd4, 32'd4};
    vt[11] = '{CMD_READ,       32'h00012080, 0, 1'b0, 1'b0, 0, -1, 1, 32'h00002080, 1, 32'h00012080, 32'd6, 32'd3, 32'd4, 32'd5};
    vt[12] = '{CMD_WRITE,      32'h00002080, 0, 1'b0, 1'b0, 0, -1, 0, 32'h0,        1, 32'h00002080, 32'd6, 32'd4, 32'd4, 32'd6};
    vt[13] = '{CMD_CLR,        32'h00000000, 0, 1'b0, 1'b0, 0, 65, 0, 32'h0,        0, 32'h0,        32'd0, 32'd0, 32'd0, 32'd0};
    vt[14] = '{CMD_READ,       32'h00011040, 0, 1'b0, 1'b0, 0, -1, 0, 32'h0,        1, 32'h00011040, 32'd1, 32'd0, 32'd0, 32'd1};
    vt[15] = '{CMD_READ,       32'h00002080, 0, 1'b0, 1'b0, 0, -1, 0, 32'h0,        1, 32'h00002080, 32'd2, 32'd0, 32'd0, 32'd2};
    vt[16] = '{CMD_PRINT,      32'h00000000, 0, 1'b0, 1'b0, 1,  1, 0, 32'h0,        0, 32'h0,        32'd2, 32'd0, 32'd0, 32'd2};
    vt[17] = '{CMD_INVALID,    32'h00000000, 0, 1'b0, 1'b1, 0,  1, 0, 32'h0,        0, 32'h0,        32'd2, 32'd0, 32'd0, 32'd2};
    vt[18] = '{CMD_I_FETCH,    32'h00002084, 0, 1'b1, 1'b0, 0,  2, 0, 32'h0,        0, 32'h0,        32'd3, 32'd0, 32'd1, 32'd2};

    repeat (3) @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset l2_req_valid", 64'(l2_req_valid), 64'd0);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset counters", {cache_read | cache_write, cache_hit | cache_miss}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run_cmd(vt[i].cmd, vt[i].addr, vt[i].rdy_wait, rs);
      $display("vec %0d cmd=%0d addr=0x%08h hit=%0b err=%0b lat=%0d wb=%0d rd=%0d cnt=%0d/%0d/%0d/%0d",
               i, vt[i].cmd, vt[i].addr, rs.hit, rs.err, rs.lat, rs.n_wb, rs.n_rd,
               rs.r, rs.w, rs.h, rs.m);
      check($sformatf("v%0d done", i), 64'(rs.done), 64'd1);
      check($sformatf("v%0d resp_hit", i), 64'(rs.hit), 64'(vt[i].exp_hit));
      check($sformatf("v%0d resp_err", i), 64'(rs.err), 64'(vt[i].exp_err));
      check($sformatf("v%0d print_pulses", i), 64'(rs.prn), 64'(vt[i].exp_prn));
      if (vt[i].exp_lat >= 0) begin
        check($sformatf("v%0d latency", i), 64'(rs.lat), 64'(vt[i].exp_lat));
        check($sformatf("v%0d busy_cycles", i), 64'(rs.busy_cnt), 64'(vt[i].exp_lat));
      end
      check($sformatf("v%0d wb_count", i), 64'(rs.n_wb), 64'(vt[i].exp_wb));
      if (vt[i].exp_wb > 0) check($sformatf("v%0d wb_addr", i), 64'(rs.wb_a), 64'(vt[i].exp_wb_addr));
      check($sformatf("v%0d rd_count", i), 64'(rs.n_rd), 64'(vt[i].exp_rd));
      if (vt[i].exp_rd > 0) check($sformatf("v%0d rd_addr", i), 64'(rs.rd_a), 64'(vt[i].exp_rd_addr));
      check($sformatf("v%0d l2_stable", i), 64'(rs.stable), 64'd1);
      check($sformatf("v%0d ready_low_busy", i), 64'(rs.rdy_ok), 64'd1);
      check($sformatf("v%0d cache_read", i), 64'(rs.r), 64'(vt[i].r));
      check($sformatf("v%0d cache_write", i), 64'(rs.w), 64'(vt[i].w));
      check($sformatf("v%0d cache_hit", i), 64'(rs.h), 64'(vt[i].h));
      check($sformatf("v%0d cache_miss", i), 64'(rs.m), 64'(vt[i].m));
    end

    // Reset while a fill request is held pending: request drops at once.
    @(negedge clk);
    req_valid = 1'b1; req_cmd = CMD_READ; req_addr = 32'h00003000;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 20 && !l2_req_valid; k++) @(negedge clk);
    check("rstA l2_req_valid before", 64'(l2_req_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("rstA during FILL_REQ: l2_req_valid=%0b req_ready=%0b busy=%0b", l2_req_valid, req_ready, busy);
    check("rstA l2_req_valid", 64'(l2_req_valid), 64'd0);
    check("rstA req_ready", 64'(req_ready), 64'd1);
    check("rstA busy", 64'(busy), 64'd0);
    check("rstA counters", {cache_read, cache_miss}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while waiting for fill data; a late response must not install the line.
    @(negedge clk);
    req_valid = 1'b1; req_cmd = CMD_READ; req_addr = 32'h00003000;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 20 && !l2_req_valid; k++) @(negedge clk);
    check("rstB l2_req_valid before", 64'(l2_req_valid), 64'd1);
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    check("rstB busy in fill_wait", 64'(busy), 64'd1);
    check("rstB counters before", {cache_read, cache_miss}, {32'd1, 32'd1});
    #2 rst_n = 1'b0;
    #1;
    $display("rstB during FILL_WAIT: req_ready=%0b read=%0d miss=%0d", req_ready, cache_read, cache_miss);
    check("rstB req_ready", 64'(req_ready), 64'd1);
    check("rstB counters", {cache_read, cache_miss}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    l2_rsp_valid = 1'b1;
    @(negedge clk);
    l2_rsp_valid = 1'b0;
    check("rstB late rsp resp_valid", 64'(resp_valid), 64'd0);
    check("rstB late rsp busy", 64'(busy), 64'd0);
    run_cmd(CMD_READ, 32'h00003000, 0, rs);
    $display("rstB re-read hit=%0b rd=%0d rd_addr=0x%08h read=%0d miss=%0d",
             rs.hit, rs.n_rd, rs.rd_a, rs.r, rs.m);
    check("rstB reread done", 64'(rs.done), 64'd1);
    check("rstB reread hit", 64'(rs.hit), 64'd0);
    check("rstB reread rd_count", 64'(rs.n_rd), 64'd1);
    check("rstB reread rd_addr", 64'(rs.rd_a), 64'h00003000);
    check("rstB reread counters", {rs.r, rs.m}, {32'd1, 32'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
